pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage MIPS pipeline. It sits alongside the forwarding unit and resolves the hazards forwarding cannot cover.
- Those hazards are load-use stalls, the multi-cycle iterative mul/div unit occupying EX, and taken-branch flushes resolved in MEM.
- It drives the PC/IF-ID write enables, the bubble/flush controls of each pipeline register, and the mul/div start/abort strobes.

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/muldiv_timer.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, default mul/div latency and control-vector presets.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN = 2'b00,
        S_MD  = 2'b01
    } state_e;

    localparam int unsigned MD_CYCLES_DEF = 8;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic md_start;
        logic md_abort;
    } ctrl_t;

    // NOP vector: what every control output reads while the block is in reset.
    localparam ctrl_t CTRL_NOP = ctrl_t'(8'b0000_0000);
    localparam ctrl_t CTRL_RUN = ctrl_t'(8'b1110_0000);

endpackage

// File: rtl/muldiv_timer.sv
// Loadable down-counter tracking the remaining mul/div stall cycles.
// Priority: clear over load over decrement; zero_o flags an expired count.
module muldiv_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, iterative mul/div and branch flush.
// Define HAZARD_PERF_EN to build the saturating performance counters; otherwise they read 0.
module pipeline_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_CYCLES = MD_CYCLES_DEF,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned PERF_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        if_id_rs_i,
    input  logic [4:0]        if_id_rt_i,
    input  logic [4:0]        id_ex_rt_i,
    input  logic              id_ex_memread_i,
    input  logic              id_ex_muldiv_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              id_ex_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              ex_mem_bubble_o,
    output logic              md_start_o,
    output logic              md_abort_o,
    output logic              md_busy_o,
    output logic [PERF_W-1:0] ld_stall_cnt_o,
    output logic [PERF_W-1:0] md_stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 2);

    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   md_load, md_dec, md_clr, md_zero;
    logic   ld_use, md_stall, ld_hit;

    assign ld_hit = id_ex_memread_i && (id_ex_rt_i != '0) &&
                    ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

    muldiv_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (md_load),
        .load_val_i (MD_LOAD),
        .dec_i      (md_dec),
        .clr_i      (md_clr),
        .zero_o     (md_zero)
    );

    always_comb begin
        ctrl     = CTRL_RUN;
        state_d  = state_q;
        md_load  = 1'b0;
        md_dec   = 1'b0;
        md_clr   = 1'b0;
        md_stall = 1'b0;
        ld_use   = 1'b0;
        if (branch_taken_i) begin
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_ex_bubble  = 1'b1;
            ctrl.ex_mem_bubble = 1'b1;
            if (state_q == S_MD) begin
                ctrl.md_abort = 1'b1;
                state_d       = S_RUN;
                md_clr        = 1'b1;
            end
        end else if (state_q == S_MD) begin
            // Count reaching zero is the cycle the result drops into EX/MEM.
            if (!md_zero) begin
                ctrl.pc_write      = 1'b0;
                ctrl.if_id_write   = 1'b0;
                ctrl.id_ex_write   = 1'b0;
                ctrl.ex_mem_bubble = 1'b1;
                md_dec             = 1'b1;
                md_stall           = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end else if (id_ex_muldiv_i) begin
            ctrl.md_start      = 1'b1;
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            ctrl.id_ex_write   = 1'b0;
            ctrl.ex_mem_bubble = 1'b1;
            state_d            = S_MD;
            md_load            = 1'b1;
            md_stall           = 1'b1;
        end else if (ld_hit) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
            ld_use            = 1'b1;
        end
        if (!rst_i) begin
            ctrl = CTRL_NOP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign pc_write_o      = ctrl.pc_write;
    assign if_id_write_o   = ctrl.if_id_write;
    assign id_ex_write_o   = ctrl.id_ex_write;
    assign if_id_flush_o   = ctrl.if_id_flush;
    assign id_ex_bubble_o  = ctrl.id_ex_bubble;
    assign ex_mem_bubble_o = ctrl.ex_mem_bubble;
    assign md_start_o      = ctrl.md_start;
    assign md_abort_o      = ctrl.md_abort;
    assign md_busy_o       = (state_q == S_MD);

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] ld_cnt_q, ld_cnt_d, md_cnt_q, md_cnt_d, fl_cnt_q, fl_cnt_d;

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        md_cnt_d = md_cnt_q;
        fl_cnt_d = fl_cnt_q;
        if (ld_use && !(&ld_cnt_q)) begin
            ld_cnt_d = ld_cnt_q + PERF_W'(1);
        end
        if (md_stall && !(&md_cnt_q)) begin
            md_cnt_d = md_cnt_q + PERF_W'(1);
        end
        if (branch_taken_i && !(&fl_cnt_q)) begin
            fl_cnt_d = fl_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ld_cnt_q <= '0;
            md_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            md_cnt_q <= md_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    assign ld_stall_cnt_o = ld_cnt_q;
    assign md_stall_cnt_o = md_cnt_q;
    assign flush_cnt_o    = fl_cnt_q;
`else
    logic unused_perf;
    assign unused_perf    = ^{ld_use, md_stall};
    assign ld_stall_cnt_o = '0;
    assign md_stall_cnt_o = '0;
    assign flush_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MD = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  if_id_rs_i = '0, if_id_rt_i = '0, id_ex_rt_i = '0;
    logic        id_ex_memread_i = 1'b0, id_ex_muldiv_i = 1'b0, branch_taken_i = 1'b0;
    logic        pc_write_o, if_id_write_o, id_ex_write_o, if_id_flush_o;
    logic        id_ex_bubble_o, ex_mem_bubble_o, md_start_o, md_abort_o, md_busy_o;
    logic [31:0] ld_stall_cnt_o, md_stall_cnt_o, flush_cnt_o;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(.MD_CYCLES(MD), .CNT_W(4), .PERF_W(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .if_id_rs_i      (if_id_rs_i),
        .if_id_rt_i      (if_id_rt_i),
        .id_ex_rt_i      (id_ex_rt_i),
        .id_ex_memread_i (id_ex_memread_i),
        .id_ex_muldiv_i  (id_ex_muldiv_i),
        .branch_taken_i  (branch_taken_i),
        .pc_write_o      (pc_write_o),
        .if_id_write_o   (if_id_write_o),
        .id_ex_write_o   (id_ex_write_o),
        .if_id_flush_o   (if_id_flush_o),
        .id_ex_bubble_o  (id_ex_bubble_o),
        .ex_mem_bubble_o (ex_mem_bubble_o),
        .md_start_o      (md_start_o),
        .md_abort_o      (md_abort_o),
        .md_busy_o       (md_busy_o),
        .ld_stall_cnt_o  (ld_stall_cnt_o),
        .md_stall_cnt_o  (md_stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    int checks = 0;
    int failures = 0;
    // Model state: cycles the current mul/div still has to spend in EX after this one.
    int md_left = 0;
    int n_ld = 0, n_md = 0, n_fl = 0;

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected vector order: pc,if_id_w,id_ex_w,flush,id_ex_bub,ex_mem_bub,start,abort,busy
    task automatic check(string tag);
        logic [8:0] e, o;
        bit busy;
        if (!rst_i) begin
            md_left = 0;
            n_ld = 0; n_md = 0; n_fl = 0;
        end
`ifdef HAZARD_PERF_EN
        cmp({tag, "_ldcnt"}, ld_stall_cnt_o, 32'(n_ld));
        cmp({tag, "_mdcnt"}, md_stall_cnt_o, 32'(n_md));
        cmp({tag, "_flcnt"}, flush_cnt_o, 32'(n_fl));
`else
        cmp({tag, "_cnts"}, ld_stall_cnt_o | md_stall_cnt_o | flush_cnt_o, 32'd0);
`endif
        e = 9'b111_000_000;
        if (!rst_i) begin
            e = '0;
        end else begin
            busy = (md_left > 0);
            e[0] = busy;
            if (branch_taken_i) begin
                e[5] = 1'b1; e[4] = 1'b1; e[3] = 1'b1;
                e[1] = busy;
                md_left = 0;
                n_fl++;
            end else if (busy) begin
                if (md_left > 1) begin
                    e[8:6] = 3'b000; e[3] = 1'b1;
                    n_md++;
                end
                md_left--;
            end else if (id_ex_muldiv_i) begin
                e[8:6] = 3'b000; e[3] = 1'b1; e[2] = 1'b1;
                md_left = MD - 1;
                n_md++;
            end else if (id_ex_memread_i && id_ex_rt_i != 0 &&
                         (id_ex_rt_i == if_id_rs_i || id_ex_rt_i == if_id_rt_i)) begin
                e[8] = 1'b0; e[7] = 1'b0; e[4] = 1'b1;
                n_ld++;
            end
        end
        o = {pc_write_o, if_id_write_o, id_ex_write_o, if_id_flush_o, id_ex_bubble_o,
             ex_mem_bubble_o, md_start_o, md_abort_o, md_busy_o};
        cmp(tag, 32'(o), 32'(e));
    endtask

    task automatic cyc(bit rst, int rs, int rt, int exrt, bit mr, bit md, bit br, string tag);
        @(negedge clk_i);
        rst_i           = rst;
        if_id_rs_i      = 5'(rs);
        if_id_rt_i      = 5'(rt);
        id_ex_rt_i      = 5'(exrt);
        id_ex_memread_i = mr;
        id_ex_muldiv_i  = md;
        branch_taken_i  = br;
        #1;
        check(tag);
    endtask

    initial begin
        int stalls, starts;
        #1;
        check("reset");
        cyc(0, 0, 0, 0, 0, 0, 0, "reset_hold");
        cyc(1, 0, 0, 0, 0, 0, 0, "idle");

        // Load-use on rs, then the bubble in EX clears it
        cyc(1, 5, 0, 5, 1, 0, 0, "ld_use_rs");
        cmp("ld_use_pc", 32'(pc_write_o), 32'd0);
        cyc(1, 5, 0, 5, 0, 0, 0, "ld_clear");
        cmp("ld_clear_pc", 32'(pc_write_o), 32'd1);
        cyc(1, 1, 7, 7, 1, 0, 0, "ld_use_rt");
        cyc(1, 0, 0, 0, 1, 0, 0, "ld_r0");
        cmp("ld_r0_pc", 32'(pc_write_o), 32'd1);

        // Full mul/div occupancy
        stalls = 0; starts = 0;
        for (int i = 0; i < int'(MD); i++) begin
            cyc(1, 0, 0, 0, 0, 1, 0, "md_seq");
            if (!pc_write_o) stalls++;
            if (md_start_o) starts++;
        end
        cmp("md_stalls", 32'(stalls), 32'(MD - 1));
        cmp("md_starts", 32'(starts), 32'd1);
        cmp("md_last_exmem", 32'(ex_mem_bubble_o), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, "md_done");
        cmp("md_busy_fell", 32'(md_busy_o), 32'd0);

        // Branch while the counter holds 3
        cyc(1, 0, 0, 0, 0, 1, 0, "ab_start");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1, 0, "ab_wait");
        cyc(1, 0, 0, 0, 0, 1, 1, "ab_branch");
        cmp("ab_abort", 32'(md_abort_o), 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, "ab_after");
        cmp("ab_after_pc", 32'(pc_write_o), 32'd1);

        // Branch coincident with a mul/div start
        cyc(1, 0, 0, 0, 0, 1, 1, "co_branch");
        cmp("co_nostart", 32'(md_start_o), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, "co_after");

        // Reset in the middle of a mul/div
        cyc(1, 0, 0, 0, 0, 1, 0, "rm_start");
        cyc(1, 0, 0, 0, 0, 1, 0, "rm_wait");
        cyc(0, 0, 0, 0, 0, 1, 0, "rm_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, "rm_hold");
        cyc(1, 0, 0, 0, 0, 0, 0, "rm_release");
        cmp("rm_noabort", 32'(md_abort_o), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cyc(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
